// File: rtl/cic_comb_decimator.sv
//------------------------------------------------------------------------------
// Module   : cic_comb_decimator
// Brief    : Per-channel 1-in-R decimator followed by NSTAGES CIC comb stages.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cic_comb_decimator #(
  parameter int WIDTH   = 64,
  parameter int NSTAGES = 5,
  parameter int DECW    = 10
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic [DECW-1:0]  cfg_decim_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic [1:0]       ch_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int c_NCH = 4;
  localparam int c_STW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam logic [c_STW-1:0] c_LAST_STAGE = c_STW'(NSTAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COMB = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [DECW-1:0]    r_dec_cnt [c_NCH];
  logic [WIDTH-1:0]   r_delay   [c_NCH][NSTAGES];
  logic [WIDTH-1:0]   r_work;
  logic [1:0]         r_ch;
  logic [c_STW-1:0]   r_stage;

  logic               w_accept;
  logic               w_keep;
  logic [DECW-1:0]    w_r_minus1;
  logic [WIDTH-1:0]   w_cur_delay;

  // A ratio of 0 behaves as 1, i.e. every sample is kept.
  assign w_r_minus1 = (cfg_decim_i == '0) ? '0 : (cfg_decim_i - DECW'(1));
  assign w_keep     = (r_dec_cnt[sel_i] >= w_r_minus1);
  assign w_accept   = data_valid_i & data_ready_o;

  always_comb begin
    w_cur_delay = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      if (r_stage == c_STW'(k)) begin
        w_cur_delay = r_delay[r_ch][k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    data_ready_o = 1'b0;
    data_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        data_ready_o = 1'b1;
        if (w_accept && w_keep) begin
          w_state_nxt = S_COMB;
        end
      end
      S_COMB: begin
        if (r_stage == c_LAST_STAGE) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        data_valid_o = 1'b1;
        if (data_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (clr_i) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_work  <= '0;
      r_ch    <= '0;
      r_stage <= '0;
      for (int c = 0; c < c_NCH; c++) begin
        r_dec_cnt[c] <= '0;
        for (int k = 0; k < NSTAGES; k++) begin
          r_delay[c][k] <= '0;
        end
      end
    end else if (clr_i) begin
      r_work  <= '0;
      r_ch    <= '0;
      r_stage <= '0;
      for (int c = 0; c < c_NCH; c++) begin
        r_dec_cnt[c] <= '0;
        for (int k = 0; k < NSTAGES; k++) begin
          r_delay[c][k] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_keep) begin
              r_dec_cnt[sel_i] <= '0;
              r_work           <= data_i;
              r_ch             <= sel_i;
              r_stage          <= '0;
            end else begin
              r_dec_cnt[sel_i] <= r_dec_cnt[sel_i] + DECW'(1);
            end
          end
        end
        S_COMB: begin
          // Modulo-2^WIDTH difference; wrap cancels the integrator wrap.
          r_work  <= r_work - w_cur_delay;
          r_stage <= r_stage + c_STW'(1);
          for (int k = 0; k < NSTAGES; k++) begin
            if (r_stage == c_STW'(k)) begin
              r_delay[r_ch][k] <= r_work;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_o = r_work;
  assign ch_o   = r_ch;

endmodule

`default_nettype wire

// File: doc/cic_comb_decimator.md
Name: cic_comb_decimator

Overview:
Downstream neighbour of the CIC integrator in the uDMA I2S PDM receive path. Takes time-multiplexed integrator outputs for up to 4 channels and keeps 1 of every R samples per channel. Each kept sample passes through NSTAGES comb (differentiator) stages. Results are presented on a valid/ready output towards the sample-formatting logic.

Parameters:
WIDTH, 64, datapath width of input, comb delay registers and output.
NSTAGES, 5, number of comb stages (1..8).
DECW, 10, width of the decimation-ratio configuration field.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  asynchronous active-low reset.
clr_i  in  1  synchronous clear of all state (sync with integrator clr).
cfg_decim_i  in  DECW  decimation ratio R; value 0 treated as 1; quasi-static.
data_valid_i  in  1  input sample present.
data_ready_o  out  1  block can accept an input sample this cycle.
sel_i  in  2  channel index of input sample.
data_i  in  WIDTH  integrator output sample.
data_valid_o  out  1  comb output valid.
data_ready_i  in  1  downstream accepts output.
ch_o  out  2  channel index of output sample.
data_o  out  WIDTH  comb output sample.

Behaviour:
- Reset (async): FSM=IDLE; all decimation counters, comb delay registers, data_o and ch_o = 0; data_valid_o = 0; data_ready_o = 1.
- State per channel c (0..3): dec_cnt[c] (DECW bits); delay[c][k] for k = 0..NSTAGES-1 (WIDTH bits each).
- FSM states: IDLE, COMB, OUT.
- data_ready_o = 1 only in IDLE.
- A sample is accepted when data_valid_i & data_ready_o.
- IDLE, accepted sample, channel c = sel_i:
  - If dec_cnt[c] >= R-1: dec_cnt[c] <= 0; latch data_i into work register, c into ch register; stage counter <= 0; go to COMB.
  - Otherwise: dec_cnt[c] <= dec_cnt[c]+1; sample is discarded; stay in IDLE.
- ">=" comparison: a counter left above R-1 by a cfg change wraps on the next sample for that channel.
- COMB: one stage per cycle for stage k = 0..NSTAGES-1:
  - work <= work - delay[c][k]; delay[c][k] <= work (pre-subtraction value).
  - After stage NSTAGES-1, go to OUT.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is intentional and cancels the integrator wrap; no saturation.
- OUT: data_valid_o = 1; data_o = work; ch_o = latched channel. Both are held stable while data_ready_i = 0. On data_ready_i = 1, go to IDLE; data_valid_o = 0 from the next cycle.
- Latency: kept sample accepted at cycle t → data_valid_o high at cycle t+NSTAGES+1. Minimum spacing between accepted decimated samples is NSTAGES+2 cycles.
- Discarded (non-kept) samples cost one cycle each.
- Channels are fully independent. Channels never addressed keep their zero state.
- clr_i (priority over all other activity, any state):
  - Next cycle: FSM=IDLE; all counters and delays = 0; data_valid_o = 0.
  - Any pending output is dropped without a handshake.
  - An input presented in the clr_i cycle is ignored.
- Simultaneous input in OUT/COMB: not accepted because data_ready_o = 0. The upstream must hold the sample.
- cfg_decim_i is sampled on every accepted sample. Changes are legal only while the path is stalled or under clr_i.

Test Plan:
- Reset release, no stimulus → data_valid_o = 0, data_ready_o = 1, data_o = 0, ch_o = 0.
- NSTAGES=1, R=2, ch0, inputs 0,10,20,30,40,50 (ready_i=1) → outputs 10,20,20, each with ch_o=0 and arriving 2 cycles after acceptance. Discarded samples produce no valid.
- NSTAGES=2, R=1, ch0, inputs 10,20,30,40 → outputs 10,0,0,0 (ramp step 10 removed by second difference).
- Interleaved ch0/ch3, R=1, NSTAGES=1: ch0 inputs 5,8; ch3 inputs 100,150 → ch0 outputs 5,3; ch3 outputs 100,50. No cross-channel leakage.
- Wrap: NSTAGES=1, R=1, WIDTH=64: inputs 0xFFFF_FFFF_FFFF_FFFE then 0x1 → outputs 0xFFFF_FFFF_FFFF_FFFE then 3.
- Backpressure and clear: hold data_ready_i=0 for 5 cycles in OUT → data_o and ch_o stable, data_ready_o = 0. Then assert clr_i → data_valid_o = 0 next cycle. The next ch0 input 7 with R=1, NSTAGES=1 outputs 7.
